// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: shares one pipelined single-precision multiplier between
// two requesters. Each accepted operand pair is registered onto the multiplier
// inputs. A tag pipeline records which requester owns each in-flight result,
// so the result and its flags can be steered back to that requester.
//
// Handshake: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both high. reqN_ready is a combinational grant, so it can
// depend on reqN_valid in the same cycle. Responses have no ready signal. An
// rspN_valid pulse is a single cycle long, and the requester must take the
// response in that cycle.
module mul_share_arbiter #(
  parameter int LAT = 3
) (
  input  logic        CLK,
  input  logic        RST,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic [1:0]  req0_rmode,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  input  logic [1:0]  req1_rmode,

  output logic        mul_Sx,
  output logic        mul_Sy,
  output logic [7:0]  mul_Ex,
  output logic [7:0]  mul_Ey,
  output logic [22:0] mul_Mx,
  output logic [22:0] mul_My,
  output logic [1:0]  mul_R_mode,

  input  logic        mul_Sz,
  input  logic [7:0]  mul_Ez,
  input  logic [22:0] mul_Mz,
  input  logic [4:0]  mul_flags,

  output logic        rsp0_valid,
  output logic [31:0] rsp0_z,
  output logic [4:0]  rsp0_flags,

  output logic        rsp1_valid,
  output logic [31:0] rsp1_z,
  output logic [4:0]  rsp1_flags,

  output logic        busy
);

  // last_grant holds the requester that won the most recent accept. A value
  // of 1 means requester 0 has priority at the next contention.
  logic           last_grant;
  logic           grant0;
  logic           grant1;
  logic           accept;
  logic [31:0]    sel_x;
  logic [31:0]    sel_y;
  logic [1:0]     sel_rmode;

  // Ownership tags. Entry 0 is loaded at the accept edge, and entry LAT lines
  // up with the multiplier result for that operation.
  logic [LAT:0]   tag_valid;
  logic [LAT:0]   tag_id;

  logic           ret0;
  logic           ret1;

  // Round-robin grant: a lone requester always wins, and under contention
  // the requester that did not win last time wins.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = grant0 && !RST;
  assign req1_ready = grant1 && !RST;
  assign accept     = req0_ready || req1_ready;

  // Operand mux that feeds the multiplier input registers.
  always_comb begin
    sel_x     = grant1 ? req1_x     : req0_x;
    sel_y     = grant1 ? req1_y     : req0_y;
    sel_rmode = grant1 ? req1_rmode : req0_rmode;
  end

  // Arbitration history. It changes only when an accept happens.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant1;
    end
  end

  // Multiplier operand registers. The fields are split out on accept and
  // held otherwise, so the multiplier inputs do not toggle when idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mul_Sx     <= 1'b0;
      mul_Sy     <= 1'b0;
      mul_Ex     <= 8'd0;
      mul_Ey     <= 8'd0;
      mul_Mx     <= 23'd0;
      mul_My     <= 23'd0;
      mul_R_mode <= 2'd0;
    end else if (accept) begin
      mul_Sx     <= sel_x[31];
      mul_Ex     <= sel_x[30:23];
      mul_Mx     <= sel_x[22:0];
      mul_Sy     <= sel_y[31];
      mul_Ey     <= sel_y[30:23];
      mul_My     <= sel_y[22:0];
      mul_R_mode <= sel_rmode;
    end
  end

  // Tag pipeline. It shifts every edge with no stall, mirroring the
  // fixed-latency multiplier. A reset empties it, so in-flight results are
  // never reported.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid <= {tag_valid[LAT-1:0], accept};
      tag_id    <= {tag_id[LAT-1:0], grant1};
    end
  end

  // These decode which requester owns the result presented this cycle.
  assign ret0 = tag_valid[LAT] && !tag_id[LAT];
  assign ret1 = tag_valid[LAT] &&  tag_id[LAT];

  // Response registers for requester 0. The data holds after the valid
  // pulse ends.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp0_valid <= 1'b0;
      rsp0_z     <= 32'd0;
      rsp0_flags <= 5'd0;
    end else begin
      rsp0_valid <= ret0;
      if (ret0) begin
        rsp0_z     <= {mul_Sz, mul_Ez, mul_Mz};
        rsp0_flags <= mul_flags;
      end
    end
  end

  // Response registers for requester 1. The data holds after the valid
  // pulse ends.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp1_valid <= 1'b0;
      rsp1_z     <= 32'd0;
      rsp1_flags <= 5'd0;
    end else begin
      rsp1_valid <= ret1;
      if (ret1) begin
        rsp1_z     <= {mul_Sz, mul_Ez, mul_Mz};
        rsp1_flags <= mul_flags;
      end
    end
  end

  assign busy = (|tag_valid) || rsp0_valid || rsp1_valid;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Testbench for mul_share_arbiter. A LAT-deep behavioural multiplier answers
// the multiplier port. A scoreboard queue holds the expected responses, and a
// negedge monitor checks routing, data, latency, busy and hold behaviour.
module tb_mul_share_arbiter;
  localparam int LAT = 3;

  logic        CLK;
  logic        RST;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_x, req0_y;
  logic [1:0]  req0_rmode;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_x, req1_y;
  logic [1:0]  req1_rmode;
  logic        mul_Sx, mul_Sy;
  logic [7:0]  mul_Ex, mul_Ey;
  logic [22:0] mul_Mx, mul_My;
  logic [1:0]  mul_R_mode;
  logic        mul_Sz;
  logic [7:0]  mul_Ez;
  logic [22:0] mul_Mz;
  logic [4:0]  mul_flags;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_z, rsp1_z;
  logic [4:0]  rsp0_flags, rsp1_flags;
  logic        busy;

  mul_share_arbiter #(.LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x),
    .req0_y(req0_y), .req0_rmode(req0_rmode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x),
    .req1_y(req1_y), .req1_rmode(req1_rmode),
    .mul_Sx(mul_Sx), .mul_Sy(mul_Sy), .mul_Ex(mul_Ex), .mul_Ey(mul_Ey),
    .mul_Mx(mul_Mx), .mul_My(mul_My), .mul_R_mode(mul_R_mode),
    .mul_Sz(mul_Sz), .mul_Ez(mul_Ez), .mul_Mz(mul_Mz), .mul_flags(mul_flags),
    .rsp0_valid(rsp0_valid), .rsp0_z(rsp0_z), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_z(rsp1_z), .rsp1_flags(rsp1_flags),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference single-precision multiply. It treats denormals as zero and
  // truncates the significand, which is enough to give distinct,
  // recognisable results. It returns {z[31:0], flags[4:0]}.
  function automatic logic [36:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic s, xn, yn, xi, yi, xz, yz, inx;
    logic [7:0] ex, ey;
    logic [47:0] p;
    logic [22:0] m;
    logic [31:0] z;
    logic [4:0] f;
    int e;
    s  = x[31] ^ y[31];
    ex = x[30:23];
    ey = y[30:23];
    xn = (ex == 8'hFF) && (x[22:0] != 0);
    yn = (ey == 8'hFF) && (y[22:0] != 0);
    xi = (ex == 8'hFF) && (x[22:0] == 0);
    yi = (ey == 8'hFF) && (y[22:0] == 0);
    xz = (ex == 8'h00);
    yz = (ey == 8'h00);
    f = 5'd0;
    z = 32'd0;
    if (xn || yn || (xi && yz) || (yi && xz)) begin
      z = 32'h7FFFFFFF;
      f[4] = 1'b1;
    end else if (xi || yi) begin
      z = {s, 8'hFF, 23'd0};
    end else if (xz || yz) begin
      z = {s, 31'd0};
      f[0] = 1'b1;
    end else begin
      p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
      e = int'(ex) + int'(ey) - 127;
      if (p[47]) begin
        m = p[46:24];
        inx = |p[23:0];
        e = e + 1;
      end else begin
        m = p[45:23];
        inx = |p[22:0];
      end
      if (e >= 255) begin
        z = {s, 8'hFF, 23'd0};
        f[3] = 1'b1;
        f[1] = 1'b1;
      end else if (e <= 0) begin
        z = {s, 31'd0};
        f[2] = 1'b1;
        f[1] = 1'b1;
        f[0] = 1'b1;
      end else begin
        z = {s, 8'(e), m};
        f[1] = inx;
      end
    end
    return {z, f};
  endfunction

  // Behavioural multiplier: fixed latency LAT from the registered operands.
  logic [36:0] mpipe [LAT];
  always @(posedge CLK) begin
    mpipe[0] <= fp_mul({mul_Sx, mul_Ex, mul_Mx}, {mul_Sy, mul_Ey, mul_My});
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign {mul_Sz, mul_Ez, mul_Mz, mul_flags} = mpipe[LAT-1];

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        id;
    logic [31:0] z;
    logic [4:0]  f;
    logic [31:0] due;
  } exp_t;
  exp_t exp_q[$];

  int          exp_last = 1;          // requester that won the last accept
  logic [31:0] hold_x = 0, hold_y = 0; // expected mul_* operand contents
  logic [1:0]  hold_rm = 0;
  logic [31:0] hold_z0 = 0, hold_z1 = 0;
  logic [4:0]  hold_f0 = 0, hold_f1 = 0;
  int          seen_grant;            // 0/1 granted requester, 2 = none
  logic        mon_en = 1'b0;

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    exp_t e;
    if (mon_en && !RST) begin
      check("busy", 64'(busy), 64'(exp_q.size() != 0));
      if (rsp0_valid && rsp1_valid) begin
        check("rsp_both_valid", 64'({rsp0_valid, rsp1_valid}), 64'b01);
      end else if (rsp0_valid || rsp1_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'({rsp0_valid, rsp1_valid}), 64'b00);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 64'(rsp1_valid), 64'(e.id));
          check("rsp_cycle", 64'(cyc), 64'(e.due));
          if (rsp0_valid) begin
            check("rsp0_z", 64'(rsp0_z), 64'(e.z));
            check("rsp0_flags", 64'(rsp0_flags), 64'(e.f));
          end else begin
            check("rsp1_z", 64'(rsp1_z), 64'(e.z));
            check("rsp1_flags", 64'(rsp1_flags), 64'(e.f));
          end
          if (!e.id) begin hold_z0 = e.z; hold_f0 = e.f; end
          else       begin hold_z1 = e.z; hold_f1 = e.f; end
        end
      end
      if (!rsp0_valid) check("rsp0_hold", 64'({rsp0_z, rsp0_flags}), 64'({hold_z0, hold_f0}));
      if (!rsp1_valid) check("rsp1_hold", 64'({rsp1_z, rsp1_flags}), 64'({hold_z1, hold_f1}));
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic v0, input logic [31:0] x0, input logic [31:0] y0,
                       input logic [1:0] r0, input logic v1, input logic [31:0] x1,
                       input logic [31:0] y1, input logic [1:0] r1);
    logic g0, g1;
    logic [36:0] r;
    exp_t e;
    @(negedge CLK);
    req0_valid = v0; req0_x = x0; req0_y = y0; req0_rmode = r0;
    req1_valid = v1; req1_x = x1; req1_y = y1; req1_rmode = r1;
    #1;
    g0 = v0 && (!v1 || exp_last == 1);
    g1 = v1 && (!v0 || exp_last == 0);
    check("req0_ready", 64'(req0_ready), 64'(g0));
    check("req1_ready", 64'(req1_ready), 64'(g1));
    seen_grant = req1_ready ? 1 : (req0_ready ? 0 : 2);
    if (g0 || g1) begin
      hold_x  = g1 ? x1 : x0;
      hold_y  = g1 ? y1 : y0;
      hold_rm = g1 ? r1 : r0;
      r = fp_mul(hold_x, hold_y);
      e.id = g1; e.z = r[36:5]; e.f = r[4:0];
      e.due = 32'(cyc + LAT + 2);
      exp_q.push_back(e);
      exp_last = g1 ? 1 : 0;
    end
    @(posedge CLK);
    #1;
    check("mul_x", 64'({mul_Sx, mul_Ex, mul_Mx}), 64'(hold_x));
    check("mul_y", 64'({mul_Sy, mul_Ey, mul_My}), 64'(hold_y));
    check("mul_rmode", 64'(mul_R_mode), 64'(hold_rm));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 4 * LAT + 8) begin
      idle(1);
      k++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    idle(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'({req0_ready, req1_ready}), 64'd0);
    check({tag, "_mul"}, 64'({mul_Sx, mul_Ex, mul_Mx, mul_Sy, mul_Ey, mul_My, mul_R_mode}), 64'd0);
    check({tag, "_rsp_valid"}, 64'({rsp0_valid, rsp1_valid, busy}), 64'd0);
    check({tag, "_rsp_data"}, 64'({rsp0_z, rsp0_flags}), 64'd0);
    check({tag, "_rsp1_data"}, 64'({rsp1_z, rsp1_flags}), 64'd0);
  endtask

  // Reset model: everything in flight is forgotten.
  task automatic model_reset();
    exp_q.delete();
    exp_last = 1;
    hold_x = 0; hold_y = 0; hold_rm = 0;
    hold_z0 = 0; hold_z1 = 0; hold_f0 = 0; hold_f1 = 0;
  endtask

  function automatic logic [31:0] gen_op();
    case ($urandom_range(0, 9))
      0: return 32'h00000000;
      1: return 32'h7F800000;
      2: return 32'h7FC00000;
      3: return 32'h3F800000;
      4: return {1'($urandom_range(0, 1)), 8'($urandom_range(200, 254)), 23'($urandom)};
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int grants[6];
    RST = 1'b1;
    req0_valid = 1; req0_x = 32'h3F800000; req0_y = 32'h3F800000; req0_rmode = 0;
    req1_valid = 1; req1_x = 32'h3F800000; req1_y = 32'h3F800000; req1_rmode = 0;
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset");
    req0_valid = 0; req1_valid = 0;
    #2;
    RST = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Contention: requester 0 wins first, then the grants alternate.
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h3F800000 + 32'(i << 20), 32'h40000000 + 32'(i << 18), 2'(i),
            1, 32'hC0400000 + 32'(i << 19), 32'h3FC00000 + 32'(i << 17), 2'(i + 1));
      grants[i] = seen_grant;
    end
    for (int i = 0; i < 6; i++) check("contention_grant", 64'(grants[i]), 64'(i % 2));
    drain();

    // Single op: 3.0 x 2.0 on requester 0.
    drive(1, 32'h40400000, 32'h40000000, 2'd0, 0, 0, 0, 0);
    drain();

    // Streaming: requester 1 alone for 8 cycles.
    for (int i = 0; i < 8; i++)
      drive(0, 0, 0, 0, 1, gen_op(), gen_op(), 2'($urandom_range(0, 3)));
    drain();

    // Invalid operation: infinity x 0.
    drive(1, 32'h7F800000, 32'h00000000, 2'd1, 0, 0, 0, 0);
    drain();

    // Zero result on requester 1.
    drive(0, 0, 0, 0, 1, 32'h00000000, 32'h3F800000, 2'd2);
    drain();

    // Asynchronous reset with three operations in flight.
    drive(1, 32'h40400000, 32'h40400000, 2'd0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h40800000, 32'h3F000000, 2'd0);
    drive(1, 32'h41000000, 32'h40A00000, 2'd3, 1, 32'h3F800000, 32'h3F800000, 2'd0);
    #1;
    RST = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    req0_valid = 0; req1_valid = 0;
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    drive(1, 32'h40400000, 32'h40000000, 2'd0, 0, 0, 0, 0);
    drain();

    // Randomized traffic, including back-to-back and contended cycles.
    for (int i = 0; i < 120; i++)
      drive(1'($urandom_range(0, 1)), gen_op(), gen_op(), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), gen_op(), gen_op(), 2'($urandom_range(0, 3)));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin scheduler sharing one pipelined single-precision multiplier (fixed latency `LAT`) between two requesters. It accepts operand pairs over valid/ready handshakes, issues at most one operation per cycle to the multiplier inputs, and tracks requester ownership through an in-flight tag pipeline. Each result and its exception flags are routed back to the owning requester. It sits between the FPU issue logic and the multiplier core.

## Interface
- `LAT`, 3: multiplier latency in clock edges from operands applied to result valid (≥1).
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: requester 0 operand pair valid.
- `req0_ready` out 1: requester 0 accepted this cycle (combinational grant).
- `req0_x`, `req0_y` in 32: IEEE-754 single operands {S,E[7:0],M[22:0]}.
- `req0_rmode` in 2: rounding mode.
- `req1_valid`, `req1_ready`, `req1_x`, `req1_y`, `req1_rmode`: same for requester 1.
- `mul_Sx`, `mul_Sy` out 1; `mul_Ex`, `mul_Ey` out 8; `mul_Mx`, `mul_My` out 23; `mul_R_mode` out 2: registered multiplier operands.
- `mul_Sz` in 1, `mul_Ez` in 8, `mul_Mz` in 23: multiplier result.
- `mul_flags` in 5: {invalid, overflow, underflow, inexact, zero} from multiplier.
- `rsp0_valid` out 1: one-cycle pulse, result for requester 0.
- `rsp0_z` out 32, `rsp0_flags` out 5: result and flags, requester 0.
- `rsp1_valid`, `rsp1_z`, `rsp1_flags`: same for requester 1.
- `busy` out 1: any operation in flight or response pending.

## Operation
- Arbitration (combinational): only one valid → grant it; both valid → grant the requester not granted last (`last_grant` register). `reqN_ready` = grant AND NOT `RST`. At most one accept per cycle.
- `last_grant` resets to 1, so requester 0 wins the first contention. It updates only on an accept.
- On accept edge A: the granted operands are split into S/E/M fields and registered onto `mul_*`. Tag entry 0 is loaded with {valid=1, id=grant}.
- No accept: `mul_*` hold their previous values. Tag entry 0 is loaded with valid=0.
- Tag pipeline: LAT+1 entries {valid, id}. It shifts every edge unconditionally, with no stall and no backpressure.
- When tag[LAT].valid = 1, the `mul_*` result belongs to tag[LAT].id. At the next edge, {Sz,Ez,Mz} is captured into `rspN_z`, `mul_flags` into `rspN_flags`, and `rspN_valid` is set for exactly one cycle.
- The other requester's rsp registers are untouched.
- `rspN_z`/`rspN_flags` hold their last value after valid drops.
- Results are returned in issue order. Requesters must always sink a response; there is no response backpressure.
- `busy` = OR of all tag valids OR either `rsp_valid`.
- Reset (asynchronous, any time, including mid-flight):
  - all tags invalid; in-flight results are dropped and never reported;
  - `last_grant`=1;
  - all outputs 0.
- After `RST` deasserts, the first accept is possible in the first cycle with `RST` low.

## Timing
- Accept at edge A → `mul_*` valid after A → multiplier result valid after edge A+LAT → `rspN_valid` high after edge A+LAT+1.
- Latency is LAT+1 edges.
- Throughput: one operation per cycle aggregate. With both requesters continuously valid, each gets every other cycle.
- Simultaneous events: an accept and a response in the same cycle are independent. Back-to-back responses to the same requester appear on consecutive cycles.
- Reset values: `req*_ready` 0, `mul_*` 0, `rsp*_valid` 0, `rsp*_z` 0, `rsp*_flags` 0, `busy` 0.

## Test plan
The bench drives `mul_*` inputs from a LAT-deep behavioural multiplier model.
- Single op: req0 x=0x40400000, y=0x40000000 (3.0×2.0), accepted at edge A → `rsp0_valid` pulses after edge A+LAT+1 with `rsp0_z`=0x40C00000 and zero flag 0. `rsp1_valid` stays 0.
- Contention: both requesters valid for 6 cycles, each with distinct operands → grants 0,1,0,1,0,1. Responses alternate rsp0/rsp1 with matching products. `last_grant` starts at 1.
- Streaming: req1 alone valid for 8 cycles → `req1_ready` high on all 8 cycles. 8 consecutive `rsp1_valid` pulses in order. `busy` stays high until the last pulse ends.
- Invalid op: req0 x=0x7F800000, y=0x00000000 (∞×0) → `rsp0_z`=0x7FFFFFFF, `rsp0_flags[4]` (invalid)=1.
- Reset mid-flight: issue 3 ops, assert `RST` asynchronously before the first returns → no `rsp_valid` pulses for those ops. All outputs are 0 immediately. After release, a new req0 op returns correctly at LAT+1.
- Zero result: req1 x=0x00000000, y=0x3F800000 → `rsp1_z`=0x00000000, zero flag=1.
